mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage load/store engine. It sits directly after the EX/MEM pipeline register and consumes that register's MEM-side outputs. It performs the data-memory or memory-mapped-IO access and generates the byte-lane and sign handling. It holds the pipeline through a stall while a multi-cycle access is in flight, then delivers load data to the MEM/WB register.

## Interface
Parameters:
- DMEM_LATENCY, 1: cycles from dmem_en to valid dmem_rdata, range 1..7.
- IO_BASE, 32'hFFFF_FC00: addresses at or above this value go to IO, all others go to DMEM.
- IO_TIMEOUT, 255: maximum number of cycles to wait for io_ack.

Ports:
- clk in 1: single clock; all state updates on its rising edge.
- rst in 1: asynchronous, active-high reset.
- MEM_MemRead in 1: load request from EX/MEM.
- MEM_MemWrite in 1: store request from EX/MEM.
- MEM_funct3 in 3: access size and signedness (LB/LH/LW/LBU/LHU, SB/SH/SW).
- MEM_ALUResult in 32: byte address.
- MEM_rs2_v in 32: store data.
- Flush in 1: kill the current MEM-stage instruction.
- dmem_en out 1: DMEM request.
- dmem_we out 4: DMEM byte write enables.
- dmem_addr out 32: DMEM word address, low two bits zeroed.
- dmem_wdata out 32: DMEM write data.
- dmem_rdata in 32: DMEM read data.
- io_req out 1: IO request.
- io_we out 1: IO write strobe.
- io_addr out 32: IO address.
- io_wdata out 32: IO write data.
- io_rdata in 32: IO read data.
- io_ack in 1: IO completion.
- stall out 1: freeze PC, IF/ID, ID/EX and EX/MEM.
- load_data out 32: extended load result to MEM/WB.
- misalign out 1: one-cycle pulse for a misaligned access.
- bus_err out 1: one-cycle pulse on IO timeout.

## Operation
- States: IDLE, DMEM_WAIT, IO_WAIT, DONE.
- IDLE, store to DMEM, aligned:
  - Drive dmem_en=1 and dmem_we from the lane mask.
  - SB: mask 4'b0001 shifted left by addr[1:0]. SH: 4'b0011 shifted left by addr[1]*2. SW: 4'b1111.
  - dmem_wdata carries the store byte or half replicated across all lanes.
  - No stall; state stays IDLE.
- IDLE, load to DMEM, aligned: drive dmem_en=1 and stall=1, load counter with DMEM_LATENCY-1, go to DMEM_WAIT.
- DMEM_WAIT: stall=1.
  - If the counter is nonzero, decrement it.
  - If the counter is zero, register the extended dmem_rdata into load_data and go to DONE.
- IDLE, any aligned access to IO: assert io_req, go to IO_WAIT.
- IO_WAIT:
  - io_req, io_we, io_addr and io_wdata are held stable; stall=1.
  - On io_ack: a read registers io_rdata into load_data; go to DONE.
  - If the timeout counter reaches IO_TIMEOUT: pulse bus_err, set load_data=0, drop io_req, go to DONE.
- DONE: stall=0 and load_data is held. The pipeline advances at this edge; next state is IDLE.
- Misaligned access (halfword with addr[0]=1, word with addr[1:0]!=0):
  - No DMEM or IO access is issued.
  - misalign pulses; load_data=0; go to DONE.
- Load extension: select a byte or half by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- Flush:
  - In IDLE: suppresses any issue.
  - In DMEM_WAIT: go to IDLE immediately and discard the data.
  - In IO_WAIT: ignored. The handshake completes and the result is dropped (next state IDLE, not DONE).
- MemRead and MemWrite both high: treated as a load.

## Timing
- Reset values: state IDLE, all outputs 0, counters 0.
- DMEM load: stall is high for DMEM_LATENCY+1 cycles, and the instruction occupies MEM for DMEM_LATENCY+2 cycles. load_data is valid from the DONE cycle.
- DMEM store: 1 cycle, no stall.
- IO: stall is high from the issue cycle through the io_ack cycle inclusive. io_ack is sampled only in IO_WAIT.
- Reset mid-access: immediately returns to IDLE and drops io_req and dmem_en. The external side tolerates the abandoned request.
- All outputs except stall, dmem_* and io_* are registered. stall and the IDLE-issue signals are decoded from state and the inputs.

## Structure
- Shared header riscv_defs.v: funct3 load/store encodings, IO_BASE default, FSM state encoding.
- Sub-module lsu_load_extend (combinational): inputs rdata, addr[1:0] and funct3; output the extended word. It is instanced once for DMEM and once for IO, or muxed in front of a single instance.

## Test plan
- LW from 0x100 with DMEM_LATENCY=2 and rdata 0xDEADBEEF → stall high 3 cycles, then load_data=0xDEADBEEF in DONE.
- LB from 0x103 with rdata 0x80AABBCC → load_data 0xFFFFFF80. LBU from the same address → 0x00000080.
- SH of 0x1234ABCD to 0x202 → dmem_we=4'b1100, dmem_wdata=0xABCDABCD, no stall.
- LW from 0xFFFFFC10 with io_ack after 5 cycles and io_rdata 0x55 → io_req high 6 cycles, load_data=0x55. With no ack → bus_err pulse after IO_TIMEOUT cycles.
- LW from 0x102 → misalign pulse, dmem_en=0, load_data=0.
- Flush in DMEM_WAIT → next cycle IDLE, stall=0, load_data unchanged. rst asserted in IO_WAIT → io_req=0 asynchronously.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store engine: funct3 encodings,
// IO window default, FSM state type and the store lane helpers.
package mem_access_unit_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FC00;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DMEM_WAIT = 2'd1,
    IO_WAIT   = 2'd2,
    DONE      = 2'd3
  } mau_state_t;

  // funct3[1:0] carries the access size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic mis;
    case (funct3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] mask;
    case (funct3[1:0])
      2'b00:   mask = 4'b0001 << off;
      2'b01:   mask = off[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] data);
    logic [31:0] wd;
    case (funct3[1:0])
      2'b00:   wd = {4{data[7:0]}};
      2'b01:   wd = {2{data[15:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load lane select and sign/zero extension.
module lsu_load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    ext_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    ext_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   ext_data = {24'd0, byte_sel};
      F3_HU:   ext_data = {16'd0, half_sel};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues DMEM or memory-mapped IO accesses,
// stalls the pipeline during multi-cycle accesses and returns extended load data.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int          DMEM_LATENCY = 1,
  parameter logic [31:0] IO_BASE      = IO_BASE_DEFAULT,
  parameter int          IO_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [2:0]  MEM_funct3,
  input  logic [31:0] MEM_ALUResult,
  input  logic [31:0] MEM_rs2_v,
  input  logic        Flush,
  output logic        dmem_en,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  output logic        io_req,
  output logic        io_we,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata,
  input  logic        io_ack,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        bus_err
);

  localparam int                LAT_W    = 3;
  localparam int                TMO_W    = $clog2(IO_TIMEOUT + 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(DMEM_LATENCY - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(IO_TIMEOUT - 1);

  mau_state_t       state;
  logic [LAT_W-1:0] lat_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [1:0]       req_off;
  logic [2:0]       req_funct3;
  logic             io_we_q;
  logic [31:0]      io_addr_q;
  logic [31:0]      io_wdata_q;
  logic             io_kill;

  logic        access_req;
  logic        is_load;
  logic        addr_io;
  logic        mis;
  logic        io_drop;
  logic [31:0] ext_src;
  logic [31:0] ext_data;

  // Issue is only decoded in IDLE; gating with rst drops requests as soon as reset rises.
  assign access_req = (state == IDLE) && (MEM_MemRead || MEM_MemWrite) && !Flush && !rst;
  assign is_load    = MEM_MemRead;
  assign addr_io    = (MEM_ALUResult >= IO_BASE);
  assign mis        = is_misaligned(MEM_funct3, MEM_ALUResult[1:0]);
  assign io_drop    = io_kill || Flush;
  assign ext_src    = (state == IO_WAIT) ? io_rdata : dmem_rdata;

  lsu_load_extend u_load_extend (
    .rdata    (ext_src),
    .addr     (req_off),
    .funct3   (req_funct3),
    .ext_data (ext_data)
  );

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    stall      = 1'b0;
    dmem_en    = 1'b0;
    dmem_we    = 4'b0000;
    dmem_addr  = 32'd0;
    dmem_wdata = 32'd0;
    io_req     = 1'b0;
    io_we      = 1'b0;
    io_addr    = 32'd0;
    io_wdata   = 32'd0;
    case (state)
      IDLE: begin
        if (access_req) begin
          if (mis) begin
            stall = 1'b1;
          end else if (addr_io) begin
            stall    = 1'b1;
            io_req   = 1'b1;
            io_we    = !is_load;
            io_addr  = MEM_ALUResult;
            io_wdata = MEM_rs2_v;
          end else begin
            dmem_en   = 1'b1;
            dmem_addr = {MEM_ALUResult[31:2], 2'b00};
            if (is_load) begin
              stall = 1'b1;
            end else begin
              dmem_we    = store_mask(MEM_funct3, MEM_ALUResult[1:0]);
              dmem_wdata = store_data(MEM_funct3, MEM_rs2_v);
            end
          end
        end
      end
      DMEM_WAIT: stall = 1'b1;
      IO_WAIT: begin
        stall    = 1'b1;
        io_req   = 1'b1;
        io_we    = io_we_q;
        io_addr  = io_addr_q;
        io_wdata = io_wdata_q;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every update in this
  // block sees the values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      tmo_cnt    <= '0;
      req_off    <= 2'b00;
      req_funct3 <= 3'b000;
      io_we_q    <= 1'b0;
      io_addr_q  <= 32'd0;
      io_wdata_q <= 32'd0;
      io_kill    <= 1'b0;
      load_data  <= 32'd0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (access_req) begin
            req_off    <= MEM_ALUResult[1:0];
            req_funct3 <= MEM_funct3;
            if (mis) begin
              misalign  <= 1'b1;
              load_data <= 32'd0;
              state     <= DONE;
            end else if (addr_io) begin
              io_we_q    <= !is_load;
              io_addr_q  <= MEM_ALUResult;
              io_wdata_q <= MEM_rs2_v;
              io_kill    <= 1'b0;
              tmo_cnt    <= '0;
              state      <= IO_WAIT;
            end else if (is_load) begin
              lat_cnt <= LAT_LOAD;
              state   <= DMEM_WAIT;
            end
          end
        end
        DMEM_WAIT: begin
          if (Flush) begin
            state <= IDLE;
          end else if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
          end else begin
            load_data <= ext_data;
            state     <= DONE;
          end
        end
        IO_WAIT: begin
          // A flushed IO access still runs its handshake; only the result is discarded.
          if (io_ack) begin
            if (io_drop) begin
              state <= IDLE;
            end else begin
              if (!io_we_q) load_data <= ext_data;
              state <= DONE;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            if (io_drop) begin
              state <= IDLE;
            end else begin
              bus_err   <= 1'b1;
              load_data <= 32'd0;
              state     <= DONE;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (Flush) io_kill <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with DMEM_LATENCY=2.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int LAT = 2;
  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MEM_MemRead, MEM_MemWrite, Flush;
  logic [2:0]  MEM_funct3;
  logic [31:0] MEM_ALUResult, MEM_rs2_v;
  logic        dmem_en;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        io_req, io_we;
  logic [31:0] io_addr, io_wdata;
  logic [31:0] io_rdata = 32'd0;
  logic        io_ack = 1'b0;
  logic        stall, misalign, bus_err;
  logic [31:0] load_data;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit #(.DMEM_LATENCY(LAT), .IO_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .MEM_funct3(MEM_funct3),
    .MEM_ALUResult(MEM_ALUResult), .MEM_rs2_v(MEM_rs2_v), .Flush(Flush),
    .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ack(io_ack),
    .stall(stall), .load_data(load_data), .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // DMEM model: read data is only valid LAT cycles after the request.
  logic [LAT-1:0] en_pipe  = '0;
  logic [31:0]    mem_word = 32'd0;
  always @(posedge clk) en_pipe <= {en_pipe[LAT-2:0], dmem_en};
  assign dmem_rdata = en_pipe[LAT-1] ? mem_word : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MEM_MemRead   = 1'b0;
    MEM_MemWrite  = 1'b0;
    MEM_funct3    = 3'b000;
    MEM_ALUResult = 32'd0;
    MEM_rs2_v     = 32'd0;
    Flush         = 1'b0;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    MEM_MemRead   = rd;
    MEM_MemWrite  = wr;
    MEM_funct3    = f3;
    MEM_ALUResult = a;
    MEM_rs2_v     = d;
    #1;
  endtask

  // Issue a DMEM load and run until stall drops; returns in the DONE cycle.
  task automatic dmem_load(input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] word, output int stall_cycles);
    mem_word = word;
    drive(1'b1, 1'b0, f3, a, 32'd0);
    stall_cycles = 0;
    while (stall && stall_cycles < 20) begin
      stall_cycles++;
      tick();
    end
  endtask

  int n;
  int req_cycles;

  initial begin
    idle_inputs();
    #1 rst = 1'b1;
    tick();
    tick();
    check("rst_stall",     32'(stall), 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_misalign",  32'(misalign), 32'd0);
    check("rst_bus_err",   32'(bus_err), 32'd0);
    check("rst_dmem_en",   32'(dmem_en), 32'd0);
    check("rst_io_req",    32'(io_req), 32'd0);
    rst = 1'b0;
    tick();

    // LW 0x100, latency 2: three stall cycles, data in DONE.
    dmem_load(F3_W, 32'h100, 32'hDEAD_BEEF, n);
    check("lw_stall_cycles", 32'(n), 32'd3);
    check("lw_load_data", load_data, 32'hDEAD_BEEF);
    check("lw_done_no_en", 32'(dmem_en), 32'd0);
    idle_inputs();
    tick();

    dmem_load(F3_B, 32'h103, 32'h80AA_BBCC, n);
    check("lb_load_data", load_data, 32'hFFFF_FF80);
    idle_inputs();
    tick();
    dmem_load(F3_BU, 32'h103, 32'h80AA_BBCC, n);
    check("lbu_load_data", load_data, 32'h0000_0080);
    idle_inputs();
    tick();
    dmem_load(F3_H, 32'h102, 32'h80AA_BBCC, n);
    check("lh_load_data", load_data, 32'hFFFF_80AA);
    idle_inputs();
    tick();
    dmem_load(F3_HU, 32'h100, 32'h80AA_BBCC, n);
    check("lhu_load_data", load_data, 32'h0000_BBCC);
    idle_inputs();
    tick();

    // Read and write both set behaves as a load (comb check only, no edge).
    drive(1'b1, 1'b1, F3_W, 32'h100, 32'h1111_2222);
    check("rdwr_we", 32'(dmem_we), 32'd0);
    check("rdwr_stall", 32'(stall), 32'd1);
    idle_inputs();
    #1;

    // Stores: single cycle, no stall.
    drive(1'b0, 1'b1, F3_H, 32'h202, 32'h1234_ABCD);
    check("sh_en", 32'(dmem_en), 32'd1);
    check("sh_we", 32'(dmem_we), 32'b1100);
    check("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    check("sh_addr", dmem_addr, 32'h200);
    check("sh_stall", 32'(stall), 32'd0);
    tick();
    drive(1'b0, 1'b1, F3_B, 32'h201, 32'h0000_0077);
    check("sb_we", 32'(dmem_we), 32'b0010);
    check("sb_wdata", dmem_wdata, 32'h7777_7777);
    tick();
    drive(1'b0, 1'b1, F3_W, 32'h204, 32'hCAFE_F00D);
    check("sw_we", 32'(dmem_we), 32'b1111);
    check("sw_wdata", dmem_wdata, 32'hCAFE_F00D);
    tick();
    idle_inputs();
    tick();

    // IO load, ack in the fifth wait cycle: io_req high six cycles.
    io_rdata = 32'h55;
    drive(1'b1, 1'b0, F3_W, 32'hFFFF_FC10, 32'd0);
    check("io_issue_addr", io_addr, 32'hFFFF_FC10);
    check("io_issue_we", 32'(io_we), 32'd0);
    req_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      if (io_req) req_cycles++;
      if (i == 3) check("io_addr_held", io_addr, 32'hFFFF_FC10);
      if (i == 5) io_ack = 1'b1;
      tick();
    end
    io_ack = 1'b0;
    check("io_req_cycles", 32'(req_cycles), 32'd6);
    check("io_done_req", 32'(io_req), 32'd0);
    check("io_done_stall", 32'(stall), 32'd0);
    check("io_load_data", load_data, 32'h55);
    idle_inputs();
    tick();

    // IO store: write strobe and data, load_data untouched.
    drive(1'b0, 1'b1, F3_W, 32'hFFFF_FC20, 32'h1357_9BDF);
    check("io_st_we", 32'(io_we), 32'd1);
    check("io_st_wdata", io_wdata, 32'h1357_9BDF);
    tick();
    io_ack = 1'b1;
    tick();
    io_ack = 1'b0;
    check("io_st_load_data", load_data, 32'h55);
    idle_inputs();
    tick();

    // Misaligned word load.
    drive(1'b1, 1'b0, F3_W, 32'h102, 32'd0);
    check("mis_no_dmem", 32'(dmem_en), 32'd0);
    check("mis_no_io", 32'(io_req), 32'd0);
    tick();
    check("mis_pulse", 32'(misalign), 32'd1);
    check("mis_load_data", load_data, 32'd0);
    idle_inputs();
    tick();
    check("mis_pulse_end", 32'(misalign), 32'd0);

    // Flush in DMEM_WAIT: back to IDLE, data discarded.
    dmem_load(F3_BU, 32'h103, 32'h80AA_BBCC, n);
    idle_inputs();
    tick();
    drive(1'b1, 1'b0, F3_W, 32'h100, 32'd0);
    mem_word = 32'hDEAD_BEEF;
    tick();
    Flush = 1'b1;
    tick();
    check("flush_dm_stall", 32'(stall), 32'd0);
    check("flush_dm_no_issue", 32'(dmem_en), 32'd0);
    idle_inputs();
    tick();
    tick();
    check("flush_dm_load_data", load_data, 32'h80);

    // Flush in IO_WAIT: handshake completes, result dropped, next state IDLE.
    io_rdata = 32'h99;
    drive(1'b1, 1'b0, F3_W, 32'hFFFF_FC10, 32'd0);
    tick();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("flush_io_req_held", 32'(io_req), 32'd1);
    io_ack = 1'b1;
    tick();
    io_ack = 1'b0;
    drive(1'b1, 1'b0, F3_W, 32'h100, 32'd0);
    check("flush_io_idle", 32'(dmem_en), 32'd1);
    check("flush_io_load_data", load_data, 32'h80);
    idle_inputs();
    #1;
    tick();

    // IO timeout: bus_err visible after TMO wait cycles plus the issue cycle.
    drive(1'b1, 1'b0, F3_W, 32'hFFFF_FC10, 32'd0);
    n = 0;
    while (!bus_err && n < 400) begin
      n++;
      tick();
    end
    check("tmo_cycles", 32'(n), 32'(TMO + 1));
    check("tmo_load_data", load_data, 32'd0);
    check("tmo_io_req", 32'(io_req), 32'd0);
    idle_inputs();
    tick();
    check("tmo_pulse_end", 32'(bus_err), 32'd0);

    // Reset while in IO_WAIT drops io_req without a clock edge.
    drive(1'b1, 1'b0, F3_W, 32'hFFFF_FC10, 32'd0);
    tick();
    check("rst_mid_req_pre", 32'(io_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_io_req", 32'(io_req), 32'd0);
    check("rst_mid_stall", 32'(stall), 32'd0);
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
